// File: rtl/ram_ctl_pkg.sv
// Shared definitions for the asynchronous SRAM Wishbone controller.
// The cycle counts here are also used by the CPU/Wishbone slot scheduler.
package ram_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WR_SETUP = 2'd2,
        WR_PULSE = 2'd3
    } state_t;

    localparam int READ_CYCLES   = 2;
    localparam int WRITE_CYCLES  = 3;
    localparam int MAX_WB_CYCLES = 3;

    function automatic logic is_busy(input state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/ram_ctl.sv
// Wishbone B4 pipelined single-byte bridge to an external asynchronous SRAM.
// Each accepted transfer, ack included, completes within three clocks.
module ram_ctl
    import ram_ctl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic                  wb_we_i,
    input  logic                  wb_cycle_i,
    input  logic                  wb_strobe_i,
    output logic                  wb_stall_o,
    output logic                  wb_ack_o,
    output logic                  ram_oe_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_data_oe
);

    state_t                  r_state;
    logic                    r_stall;
    logic                    r_ack;
    logic                    r_oe;
    logic                    r_we;
    logic                    r_data_oe;
    logic                    r_abort;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [ADDR_WIDTH-1:0]   r_addr;

    state_t                  w_next_state;
    logic                    w_accept;
    logic                    w_ack;
    logic                    w_oe;
    logic                    w_we;
    logic                    w_data_oe;
    logic                    w_abort;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [ADDR_WIDTH-1:0]   w_addr;

    assign w_accept = (r_state == IDLE) && wb_cycle_i && wb_strobe_i;

    // Next-state and next-output decode; the SRAM strobes are pure functions of the state entered.
    always_comb begin
        w_next_state = r_state;
        w_ack        = 1'b0;
        w_oe         = 1'b0;
        w_we         = 1'b0;
        w_data_oe    = 1'b0;
        w_abort      = r_abort;
        w_rdata      = r_rdata;
        w_wdata      = r_wdata;
        w_addr       = r_addr;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_addr  = wb_addr_i;
                    w_wdata = wb_data_i;
                    w_abort = 1'b0;
                    if (wb_we_i) begin
                        w_next_state = WR_SETUP;
                        w_data_oe    = 1'b1;
                    end else begin
                        w_next_state = READ;
                        w_oe         = 1'b1;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            READ: begin
                w_rdata      = ram_data_i;
                w_ack        = wb_cycle_i;
                w_next_state = IDLE;
            end
            WR_SETUP: begin
                // A dropped cycle only cancels the ack; the WE pulse still runs its full clock.
                w_data_oe    = 1'b1;
                w_we         = 1'b1;
                w_abort      = r_abort | ~wb_cycle_i;
                w_next_state = WR_PULSE;
            end
            WR_PULSE: begin
                w_data_oe    = 1'b1;
                w_ack        = ~r_abort & wb_cycle_i;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            r_state   <= IDLE;
            r_stall   <= 1'b0;
            r_ack     <= 1'b0;
            r_oe      <= 1'b0;
            r_we      <= 1'b0;
            r_data_oe <= 1'b0;
            r_abort   <= 1'b0;
            r_rdata   <= {DATA_WIDTH{1'b0}};
            r_wdata   <= {DATA_WIDTH{1'b0}};
            r_addr    <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_state   <= w_next_state;
            r_stall   <= is_busy(w_next_state);
            r_ack     <= w_ack;
            r_oe      <= w_oe;
            r_we      <= w_we;
            r_data_oe <= w_data_oe;
            r_abort   <= w_abort;
            r_rdata   <= w_rdata;
            r_wdata   <= w_wdata;
            r_addr    <= w_addr;
        end
    end

    assign wb_stall_o  = r_stall;
    assign wb_ack_o    = r_ack;
    assign wb_data_o   = r_rdata;
    assign ram_oe_o    = r_oe;
    assign ram_we_o    = r_we;
    assign ram_data_oe = r_data_oe;
    assign ram_addr_o  = r_addr;
    assign ram_data_o  = r_wdata;

endmodule

// File: tb/tb_ram_ctl.sv
// Directed and randomized self-checking bench for ram_ctl with a behavioural SRAM.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_ram_ctl;

    localparam int DW = 8;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          we, cyc, stb;
    logic          stall, ack;
    logic          ram_oe_o, ram_we_o, ram_data_oe;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_i, ram_data_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always #8 clk = ~clk;

    ram_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .wb_clock_i (clk),
        .wb_reset_i (rst),
        .wb_addr_i  (addr),
        .wb_data_i  (wdata),
        .wb_data_o  (rdata),
        .wb_we_i    (we),
        .wb_cycle_i (cyc),
        .wb_strobe_i(stb),
        .wb_stall_o (stall),
        .wb_ack_o   (ack),
        .ram_oe_o   (ram_oe_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_i (ram_data_i),
        .ram_data_o (ram_data_o),
        .ram_data_oe(ram_data_oe)
    );

    // SRAM model: the byte is stored at the end of a WE pulse; preload port used by the bench.
    always @(posedge clk) begin
        if (pre_en) sram[pre_addr] <= pre_data;
        else if (ram_we_o && ram_data_oe) sram[ram_addr_o] <= ram_data_o;
    end
    assign ram_data_i = ram_oe_o ? sram[ram_addr_o] : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick(); tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b exp 0", ack); end
        checks++; if ({ram_oe_o, ram_we_o, ram_data_oe} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b exp 000", {ram_oe_o, ram_we_o, ram_data_oe}); end
        checks++; if (ram_addr_o !== 17'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", ram_addr_o); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 17'h12345; wdata = 8'hA5;
        tick(); // T0
        checks++; if (ram_addr_o !== 17'h12345) begin errors++; $display("FAIL wr_addr_t0: got %h exp 12345", ram_addr_o); end
        checks++; if (ram_data_o !== 8'hA5) begin errors++; $display("FAIL wr_data_t0: got %h exp a5", ram_data_o); end
        checks++; if ({ram_data_oe, ram_we_o, stall, ack} !== 4'b1010) begin errors++; $display("FAIL wr_t0: doe/we/stall/ack got %b exp 1010", {ram_data_oe, ram_we_o, stall, ack}); end
        stb = 1'b0; we = 1'b0; addr = 17'h0; wdata = 8'h00;
        tick(); // T1
        checks++; if ({ram_data_oe, ram_we_o, stall, ack, ram_oe_o} !== 5'b11100) begin errors++; $display("FAIL wr_t1: doe/we/stall/ack/oe got %b exp 11100", {ram_data_oe, ram_we_o, stall, ack, ram_oe_o}); end
        checks++; if (ram_addr_o !== 17'h12345) begin errors++; $display("FAIL wr_addr_t1: got %h exp 12345", ram_addr_o); end
        tick(); // T2
        checks++; if ({ram_data_oe, ram_we_o, stall, ack} !== 4'b1001) begin errors++; $display("FAIL wr_t2: doe/we/stall/ack got %b exp 1001", {ram_data_oe, ram_we_o, stall, ack}); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_unchanged: got %h exp 0", rdata); end
        tick(); // T3
        checks++; if ({ram_data_oe, ack} !== 2'b00) begin errors++; $display("FAIL wr_t3: doe/ack got %b exp 00", {ram_data_oe, ack}); end
        checks++; if (ram_addr_o !== 17'h12345) begin errors++; $display("FAIL wr_addr_hold: got %h exp 12345", ram_addr_o); end
        checks++; if (sram[17'h12345] !== 8'hA5) begin errors++; $display("FAIL wr_sram: got %h exp a5", sram[17'h12345]); end
        cyc = 1'b0;
        tick();
    endtask

    task automatic test_read();
        preload(17'h00010, 8'h5A);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 17'h00010;
        tick(); // T0
        checks++; if ({ram_oe_o, ram_data_oe, stall, ack} !== 4'b1010) begin errors++; $display("FAIL rd_t0: oe/doe/stall/ack got %b exp 1010", {ram_oe_o, ram_data_oe, stall, ack}); end
        stb = 1'b0;
        tick(); // T1
        checks++; if ({ram_oe_o, ram_data_oe, stall, ack} !== 4'b0001) begin errors++; $display("FAIL rd_t1: oe/doe/stall/ack got %b exp 0001", {ram_oe_o, ram_data_oe, stall, ack}); end
        checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h exp 5a", rdata); end
        tick(); // T2
        checks++; if ({ack, ram_data_oe} !== 2'b00) begin errors++; $display("FAIL rd_t2: ack/doe got %b exp 00", {ack, ram_data_oe}); end
        checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rd_data_hold: got %h exp 5a", rdata); end
        cyc = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 17'h00100; wdata = 8'h11;
        tick(); // T0: write accepted
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_accept_wr: stall got %b exp 1", stall); end
        we = 1'b0; wdata = 8'hEE;
        tick(); acks += int'(ack); // T1
        tick(); acks += int'(ack); // T2: write ack cycle
        checks++; if ({ack, stall, ram_data_oe} !== 3'b101) begin errors++; $display("FAIL b2b_t2: ack/stall/doe got %b exp 101", {ack, stall, ram_data_oe}); end
        tick(); acks += int'(ack); // T3: read accepted
        checks++; if ({ram_oe_o, ram_data_oe, stall, ack} !== 4'b1010) begin errors++; $display("FAIL b2b_t3: oe/doe/stall/ack got %b exp 1010", {ram_oe_o, ram_data_oe, stall, ack}); end
        stb = 1'b0;
        tick(); acks += int'(ack); // T4: read ack
        checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL b2b_rdata: got %h exp 11", rdata); end
        tick(); acks += int'(ack);
        tick(); acks += int'(ack);
        checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d exp 2", acks); end
        cyc = 1'b0;
        tick();
    endtask

    task automatic test_cycle_drop();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 17'h00200; wdata = 8'h77;
        tick(); // T0
        stb = 1'b0;
        tick(); // T1: WR_PULSE
        checks++; if (ram_we_o !== 1'b1) begin errors++; $display("FAIL drop_we_t1: got %b exp 1", ram_we_o); end
        cyc = 1'b0;
        #3;
        checks++; if (ram_we_o !== 1'b1) begin errors++; $display("FAIL drop_we_mid: got %b exp 1", ram_we_o); end
        tick(); // T2
        checks++; if ({ram_we_o, ack, stall} !== 3'b000) begin errors++; $display("FAIL drop_t2: we/ack/stall got %b exp 000", {ram_we_o, ack, stall}); end
        tick(); // T3
        checks++; if ({ack, stall, ram_data_oe} !== 3'b000) begin errors++; $display("FAIL drop_t3: ack/stall/doe got %b exp 000", {ack, stall, ram_data_oe}); end
        checks++; if (sram[17'h00200] !== 8'h77) begin errors++; $display("FAIL drop_sram: got %h exp 77", sram[17'h00200]); end
    endtask

    task automatic test_reset_mid_write();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 17'h1FFFF; wdata = 8'h33;
        tick(); // T0
        stb = 1'b0;
        tick(); // T1: WR_PULSE
        checks++; if (ram_we_o !== 1'b1) begin errors++; $display("FAIL rstw_we_t1: got %b exp 1", ram_we_o); end
        rst = 1'b1;
        tick();
        checks++; if ({ram_we_o, ram_oe_o, ram_data_oe, ack, stall} !== 5'b00000) begin errors++; $display("FAIL rstw_ctrl: we/oe/doe/ack/stall got %b exp 00000", {ram_we_o, ram_oe_o, ram_data_oe, ack, stall}); end
        checks++; if (ram_addr_o !== 17'h0) begin errors++; $display("FAIL rstw_addr: got %h exp 0", ram_addr_o); end
        checks++; if ({ram_data_o, rdata} !== 16'h0000) begin errors++; $display("FAIL rstw_data: wdata/rdata got %h exp 0000", {ram_data_o, rdata}); end
        rst = 1'b0; cyc = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_mem [8];
        logic [7:0]    written = 8'h00;
        int            idx, acks, ack_at, want_at;
        logic          is_wr;
        for (int n = 0; n < 40; n++) begin
            idx   = int'($urandom_range(0, 7));
            is_wr = (written[idx] == 1'b0) || ($urandom_range(0, 1) == 1);
            cyc = 1'b1; stb = 1'b1; we = is_wr;
            addr = 17'h0A00 + 17'(idx); wdata = 8'($urandom_range(0, 255));
            if (is_wr) begin exp_mem[idx] = wdata; written[idx] = 1'b1; end
            tick(); // accept edge
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rnd_accept n=%0d: stall got %b exp 1", n, stall); end
            stb = 1'b0;
            acks = 0; ack_at = 0;
            want_at = is_wr ? 2 : 1;
            for (int k = 1; k <= 4; k++) begin
                tick();
                checks++; if ((ram_oe_o & ram_we_o) !== 1'b0) begin errors++; $display("FAIL rnd_oe_we n=%0d k=%0d: both high", n, k); end
                checks++; if ((ram_oe_o & ram_data_oe) !== 1'b0) begin errors++; $display("FAIL rnd_oe_doe n=%0d k=%0d: both high", n, k); end
                if (ack === 1'b1) begin
                    acks++; ack_at = k;
                    if (!is_wr) begin
                        checks++; if (rdata !== exp_mem[idx]) begin errors++; $display("FAIL rnd_rdata n=%0d: got %h exp %h", n, rdata, exp_mem[idx]); end
                    end
                end
            end
            checks++; if (acks !== 1) begin errors++; $display("FAIL rnd_ack_count n=%0d: got %0d exp 1", n, acks); end
            checks++; if (ack_at !== want_at) begin errors++; $display("FAIL rnd_ack_latency n=%0d: got %0d exp %0d", n, ack_at, want_at); end
            if ($urandom_range(0, 3) == 0) cyc = 1'b0;
        end
        cyc = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_cycle_drop();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
